lsu_stage: RTL
==============

Name: lsu_stage

Overview:
- Load/store stage directly downstream of the execute stage.
- Consumes the ALU result (used as address), store data, byte mask, load-control and writeback info.
- Performs one AXI4-Lite-style memory transaction per load/store; passes non-memory instructions straight through.
- Presents a registered result to the writeback stage over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, data width; only 32 is supported

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept an instruction
- result_in  in  32  ALU result; memory address for loads and stores
- mem_wdata_in  in  32  unaligned store data (low bytes significant)
- mem_wen, mem_ren  in  1  store / load; mutually exclusive
- wmask_in  in  4  0001 = byte, 0011 = half, 1111 = word
- load_ctrl  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd_in  in  5  destination register
- reg_wen_in  in  1  writeback enable
- pc_in  in  32  instruction PC
- out_valid  out  1  writeback data valid
- out_ready  in  1  writeback stage accepts
- rd_out, reg_wen_out  out  5/1  registered passthrough
- pc_out  out  32  registered passthrough
- wb_data  out  32  load result, or result_in for non-memory instructions
- fault  out  1  misaligned access or bus error response
- araddr, arvalid, arready, arsize  out/out/in/out  32/1/1/3  read address channel
- rdata, rresp, rvalid, rready  in/in/in/out  32/2/1/1  read data channel
- awaddr, awvalid, awready, awsize  out/out/in/out  32/1/1/3  write address channel
- wdata, wstrb, wvalid, wready  out/out/out/in  32/4/1/1  write data channel
- bresp, bvalid, bready  in/in/out  2/1/1  write response channel

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; out_valid, arvalid, awvalid, wvalid, rready, bready, fault = 0; all data registers = 0. Reset mid-transaction abandons it; nothing is replayed.
- in_ready = (state == IDLE) && (!out_valid || out_ready). An accept is in_valid && in_ready. Inputs are captured into internal registers on accept.
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE, on accept:
  - Non-memory: next cycle out_valid = 1, wb_data = result_in, fault = 0. Latency is 1 cycle and the state stays IDLE.
  - Misaligned (half with addr[0] = 1, or word with addr[1:0] != 0): no bus activity; next cycle out_valid = 1, fault = 1, wb_data = 0.
  - Aligned load: go to RADDR. Aligned store: go to WREQ.
- RADDR:
  - arvalid = 1, araddr = addr, arsize = 0/1/2 for byte/half/word.
  - On arready, go to RDATA; arvalid drops the cycle after the handshake.
- RDATA:
  - rready = 1. On rvalid: sh = rdata >> (8*addr[1:0]), then extend per load_ctrl (sign-extend bit 7/15 for LB/LH, zero-extend for LBU/LHU, LW unchanged).
  - Register the extended value into wb_data and set fault = (rresp != 0). If rresp != 0, wb_data = 0 instead.
  - Set out_valid = 1 and return to IDLE.
- WREQ:
  - awvalid and wvalid assert together, with awaddr = addr, wstrb = wmask << addr[1:0], wdata = mem_wdata << (8*addr[1:0]).
  - Each valid deasserts independently after its own handshake. Handshakes may complete in the same cycle or in either order.
  - When both have completed, go to WRESP.
- WRESP:
  - bready = 1. On bvalid: out_valid = 1, wb_data = 0, fault = (bresp != 0), return to IDLE.
- Output register:
  - out_valid and its payload hold stable until out_ready.
  - out_valid && out_ready in the same cycle as a pass-through accept reloads the register with no bubble; out_valid stays 1.
  - Otherwise out_valid clears the cycle after out_ready.
- Bus valids never drop before their ready. Address, data and strobe stay stable while their valid is high.
- A store with reg_wen_in = 1 is forwarded as given; this stage does not check it.

Decomposition:
- Shared package: load_ctrl encodings (LB/LH/LW/LBU/LHU), AXI size and resp constants, FSM state enum.
- One sub-module, lsu_align: purely combinational. Computes store lane shift and strobe, the misalignment check, and load extraction with sign/zero extension. The FSM and output register stay in lsu_stage.

Test Plan:
- Pass-through: ALU instruction with result_in = 0x1234, out_ready = 1 -> next cycle out_valid = 1, wb_data = 0x1234, no bus valids; back-to-back accepts with no bubble.
- Load LB at addr 0x80000003, rdata = 0x80FF_0000 (byte 3 = 0x80) -> wb_data = 0xFFFFFF80. LBU at the same address -> wb_data = 0x00000080. arsize = 0.
- Store SH at 0x80000002, data 0xABCD -> wstrb = 1100, wdata = 0xABCD0000. With wready two cycles after awready, awvalid drops first, then wvalid; bready is high only after both handshakes.
- Misaligned LW at 0x80000001 -> no arvalid, next cycle out_valid = 1, fault = 1, wb_data = 0.
- rresp = 2'b10 on an LW -> fault = 1, wb_data = 0. Also hold out_ready = 0 for 3 cycles -> outputs stable and in_ready = 0 throughout.
- Assert reset while in RDATA -> all valids and readies are 0 immediately (asynchronously), state is IDLE, and after release in_ready = 1.

Source files
------------

// File: rtl/lsu_stage_pkg.sv
// Shared encodings for the load/store stage: load funct3 codes, AXI size/resp
// constants and the bus FSM state type.
package lsu_stage_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [2:0] AXI_SIZE_B = 3'd0;
    localparam logic [2:0] AXI_SIZE_H = 3'd1;
    localparam logic [2:0] AXI_SIZE_W = 3'd2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_stage_align.sv
// Combinational lane logic: access size, misalignment, store lane placement
// and load byte extraction with sign/zero extension.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic        i_is_load,
    input  logic [2:0]  i_load_ctrl,
    input  logic [3:0]  i_wmask,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_rsp_addr_lo,
    input  logic [2:0]  i_rsp_ctrl,
    input  logic [31:0] i_rdata,
    output logic [2:0]  o_size,
    output logic        o_misaligned,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    logic [31:0] w_rsh;

    // Loads size from funct3, stores from the byte mask.
    always_comb begin
        o_size = AXI_SIZE_B;
        if (i_is_load) begin
            case (i_load_ctrl)
                LD_LB, LD_LBU: o_size = AXI_SIZE_B;
                LD_LH, LD_LHU: o_size = AXI_SIZE_H;
                default:       o_size = AXI_SIZE_W;
            endcase
        end else begin
            case (i_wmask)
                4'b1111: o_size = AXI_SIZE_W;
                4'b0011: o_size = AXI_SIZE_H;
                default: o_size = AXI_SIZE_B;
            endcase
        end
    end

    // Halves need an even address, words a 4-byte aligned one.
    always_comb begin
        o_misaligned = 1'b0;
        case (o_size)
            AXI_SIZE_H: o_misaligned = i_addr_lo[0];
            AXI_SIZE_W: o_misaligned = (i_addr_lo != 2'b00);
            default:    o_misaligned = 1'b0;
        endcase
    end

    assign o_wstrb = i_wmask << i_addr_lo;
    assign o_wdata = i_wdata << {i_addr_lo, 3'b000};
    assign w_rsh   = i_rdata >> {i_rsp_addr_lo, 3'b000};

    // Pick the addressed lane out of the read beat and extend it.
    always_comb begin
        o_load = w_rsh;
        case (i_rsp_ctrl)
            LD_LB:   o_load = {{24{w_rsh[7]}}, w_rsh[7:0]};
            LD_LH:   o_load = {{16{w_rsh[15]}}, w_rsh[15:0]};
            LD_LBU:  o_load = {24'h000000, w_rsh[7:0]};
            LD_LHU:  o_load = {16'h0000, w_rsh[15:0]};
            default: o_load = w_rsh;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: one AXI4-Lite style transaction per memory instruction,
// pass-through for everything else, registered valid/ready result towards writeback.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic [DATA_WIDTH-1:0] mem_wdata_in,
    input  logic                  mem_wen,
    input  logic                  mem_ren,
    input  logic [3:0]            wmask_in,
    input  logic [2:0]            load_ctrl,
    input  logic [4:0]            rd_in,
    input  logic                  reg_wen_in,
    input  logic [31:0]           pc_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            rd_out,
    output logic                  reg_wen_out,
    output logic [31:0]           pc_out,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [2:0]            arsize,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [2:0]            awsize,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    lsu_state_e r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_lctl, r_size;
    logic [4:0]            r_rd, r_rd_out;
    logic                  r_wen, r_wen_out;
    logic [31:0]           r_pc, r_pc_out;
    logic [3:0]            r_wstrb;
    logic [DATA_WIDTH-1:0] r_wdata, r_wb_data;
    logic                  r_out_valid, r_fault;
    logic                  r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;

    logic                  w_arvalid_nxt, w_rready_nxt, w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;
    logic                  w_out_valid_nxt, w_fault_nxt, w_wen_nxt;
    logic [DATA_WIDTH-1:0] w_wb_nxt;
    logic [4:0]            w_rd_nxt;
    logic [31:0]           w_pc_nxt;

    logic                  w_accept, w_misaligned;
    logic [2:0]            w_size;
    logic [3:0]            w_wstrb;
    logic [31:0]           w_wdata_lane, w_load;

    assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    lsu_align u_align (
        .i_addr_lo     (result_in[1:0]),
        .i_is_load     (mem_ren),
        .i_load_ctrl   (load_ctrl),
        .i_wmask       (wmask_in),
        .i_wdata       (mem_wdata_in),
        .i_rsp_addr_lo (r_addr[1:0]),
        .i_rsp_ctrl    (r_lctl),
        .i_rdata       (rdata),
        .o_size        (w_size),
        .o_misaligned  (w_misaligned),
        .o_wstrb       (w_wstrb),
        .o_wdata       (w_wdata_lane),
        .o_load        (w_load)
    );

    // Next state, bus valids/readies and output register contents.
    always_comb begin
        w_state_nxt     = r_state;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_out_valid_nxt = r_out_valid && !out_ready;
        w_wb_nxt        = r_wb_data;
        w_fault_nxt     = r_fault;
        w_rd_nxt        = r_rd_out;
        w_wen_nxt       = r_wen_out;
        w_pc_nxt        = r_pc_out;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !mem_ren && !mem_wen) begin
                    w_out_valid_nxt = 1'b1;
                    w_wb_nxt        = result_in;
                    w_fault_nxt     = 1'b0;
                    w_rd_nxt        = rd_in;
                    w_wen_nxt       = reg_wen_in;
                    w_pc_nxt        = pc_in;
                end else if (w_accept && w_misaligned) begin
                    w_out_valid_nxt = 1'b1;
                    w_wb_nxt        = '0;
                    w_fault_nxt     = 1'b1;
                    w_rd_nxt        = rd_in;
                    w_wen_nxt       = reg_wen_in;
                    w_pc_nxt        = pc_in;
                end else if (w_accept && mem_ren) begin
                    w_state_nxt   = ST_RADDR;
                    w_arvalid_nxt = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt   = ST_WREQ;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (arready) begin
                    w_state_nxt   = ST_RDATA;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (rvalid) begin
                    w_state_nxt     = ST_IDLE;
                    w_rready_nxt    = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_fault_nxt     = (rresp != AXI_RESP_OKAY);
                    w_wb_nxt        = (rresp == AXI_RESP_OKAY) ? w_load : '0;
                    w_rd_nxt        = r_rd;
                    w_wen_nxt       = r_wen;
                    w_pc_nxt        = r_pc;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_WREQ: begin
                // The two channels retire independently, in any order.
                w_awvalid_nxt = r_awvalid && !awready;
                w_wvalid_nxt  = r_wvalid && !wready;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_state_nxt  = ST_WRESP;
                    w_bready_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_WREQ;
                end
            end
            ST_WRESP: begin
                if (bvalid) begin
                    w_state_nxt     = ST_IDLE;
                    w_bready_nxt    = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_fault_nxt     = (bresp != AXI_RESP_OKAY);
                    w_wb_nxt        = '0;
                    w_rd_nxt        = r_rd;
                    w_wen_nxt       = r_wen;
                    w_pc_nxt        = r_pc;
                end else begin
                    w_state_nxt = ST_WRESP;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
            end
        endcase
    end

    // State register, bus control registers, output register and request capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_out_valid <= 1'b0;
            r_wb_data   <= '0;
            r_fault     <= 1'b0;
            r_rd_out    <= 5'd0;
            r_wen_out   <= 1'b0;
            r_pc_out    <= 32'd0;
            r_addr      <= '0;
            r_lctl      <= 3'd0;
            r_size      <= 3'd0;
            r_rd        <= 5'd0;
            r_wen       <= 1'b0;
            r_pc        <= 32'd0;
            r_wstrb     <= 4'd0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_wb_data   <= w_wb_nxt;
            r_fault     <= w_fault_nxt;
            r_rd_out    <= w_rd_nxt;
            r_wen_out   <= w_wen_nxt;
            r_pc_out    <= w_pc_nxt;
            if (w_accept) begin
                r_addr  <= result_in[ADDR_WIDTH-1:0];
                r_lctl  <= load_ctrl;
                r_size  <= w_size;
                r_rd    <= rd_in;
                r_wen   <= reg_wen_in;
                r_pc    <= pc_in;
                r_wstrb <= w_wstrb;
                r_wdata <= w_wdata_lane;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign wb_data     = r_wb_data;
    assign fault       = r_fault;
    assign rd_out      = r_rd_out;
    assign reg_wen_out = r_wen_out;
    assign pc_out      = r_pc_out;
    assign araddr      = r_addr;
    assign awaddr      = r_addr;
    assign arsize      = r_size;
    assign awsize      = r_size;
    assign arvalid     = r_arvalid;
    assign rready      = r_rready;
    assign awvalid     = r_awvalid;
    assign wvalid      = r_wvalid;
    assign bready      = r_bready;
    assign wstrb       = r_wstrb;
    assign wdata       = r_wdata;

endmodule
